// File: rtl/vga_sync_gen.sv
// 640x480@60 Hz VGA timing generator on the 100 MHz system clock.
// The divided pixel clock is sampled as data and edge-detected into a one-cycle
// pixel strobe. A request stage publishes the pixel position to the renderer and a
// display stage, one pixel later, emits colour and syncs aligned to that colour.
// Optional build macro: VGA_TEST_PATTERN_EN replaces rgb_in with a position-derived
// test pattern.
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        clk_pix_in,
  input  logic [11:0] rgb_in,
  output logic        pix_tick,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        video_on,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb_out
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HLast      = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast      = 10'(V_TOTAL - 1);
  localparam logic [9:0] HAct       = 10'(H_ACTIVE);
  localparam logic [9:0] VAct       = 10'(V_ACTIVE);
  localparam logic [9:0] HSyncStart = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HSyncEnd   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VSyncStart = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VSyncEnd   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic        s1_q, s2_q, s3_q;
  logic        pix_tick_q;
  logic [9:0]  h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic [9:0]  pix_x_q, pix_y_q;
  logic        video_on_q, frame_start_q;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic [11:0] rgb_q, rgb_d;
  logic [11:0] pix_rgb;

  // Synchronise and edge-detect the divided pixel clock into a one-cycle strobe.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      pix_tick_q <= 1'b0;
    end else begin
      s1_q       <= clk_pix_in;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      pix_tick_q <= s2_q & ~s3_q;
    end
  end

  // Next counter values: h advances per tick, v advances on h wrap.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_tick_q) begin
      if (h_q == HLast) begin
        h_d = '0;
        v_d = (v_q == VLast) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // Counters and request stage; both load from the updated position on a tick.
  // Counters reset to the last position so the first tick lands on (0,0).
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      h_q           <= HLast;
      v_q           <= VLast;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      frame_start_q <= 1'b0;
      if (pix_tick_q) begin
        pix_x_q       <= h_d;
        pix_y_q       <= v_d;
        video_on_q    <= (h_d < HAct) && (v_d < VAct);
        frame_start_q <= (h_d == '0) && (v_d == '0);
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic unused_rgb_in;
  assign unused_rgb_in = ^rgb_in;
  assign pix_rgb = {pix_x_q[7:4], pix_y_q[7:4], pix_x_q[3:0] ^ pix_y_q[3:0]};
`else
  assign pix_rgb = rgb_in;
`endif

  // Display-stage values derived from the request-stage position.
  always_comb begin
    rgb_d   = video_on_q ? pix_rgb : 12'h000;
    hsync_d = ~((pix_x_q >= HSyncStart) && (pix_x_q < HSyncEnd));
    vsync_d = ~((pix_y_q >= VSyncStart) && (pix_y_q < VSyncEnd));
  end

  // Display stage: captured one tick after the request so syncs match the colour.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= 12'h000;
    end else if (pix_tick_q) begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
    end
  end

  assign pix_tick    = pix_tick_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign video_on    = video_on_q;
  assign frame_start = frame_start_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign rgb_out     = rgb_q;

endmodule
